ascon_permutation_final: RTL and testbench
==========================================

Name: ascon_permutation_final

Overview:
- Registered ASCON-128 datapath: one permutation round per clock, with XOR injection before and after the round.
- Holds the 320-bit state S0..S4. An external FSM drives it through initialisation, associated data, plaintext and finalisation.
- Captures the ciphertext block (64 bits) and the tag (128 bits) into dedicated output registers.

Parameters:
- None. Widths are fixed by ASCON-128: state 5x64, key 128, data 64, round index 4 bits.

Ports:
- clock_i  in  1  rising-edge clock
- resetb_i  in  1  asynchronous active-low reset
- select_i  in  1  1: round input is permutation_i; 0: round input is the internal state register
- permutation_i  in  type_state (5x64)  external state loaded when select_i=1
- round_i  in  4  round index 0..11, selects the round constant
- enable_i  in  1  state register load enable
- xor_key_i  in  128  key K
- xor_data_i  in  64  data block (AD or plaintext)
- etat_up_i  in  2  pre-round XOR mode
- etat_down_i  in  2  post-round XOR mode
- enable_cipher  in  1  ciphertext register load enable
- enable_tag  in  1  tag register load enable
- permutation_o  out  type_state  current state register
- sortie_cipher  out  64  registered ciphertext
- sortie_tag  out  128  registered tag

Behaviour:
- Combinational path, in order: mux -> xor_up -> round -> xor_down -> state register.
- Mux: A = select_i ? permutation_i : state_reg.
- xor_up, selected by etat_up_i:
  - 00: pass-through.
  - 01: S0 ^= xor_data_i.
  - 10: S1 ^= K[127:64], S2 ^= K[63:0] (finalisation key).
  - 11: both 01 and 10.
- Round, step 1 (constant addition): S2 ^= {56'h0, c}, where c = ((4'hF - round_i) << 4) | round_i. Round 0 gives 0xF0, round 6 gives 0x96, round 11 gives 0x4B. For round_i > 11, apply c = 0.
- Round, step 2: ASCON 5-bit S-box applied bit-sliced across all 64 columns.
- Round, step 3: linear layer, with >>> denoting rotate right:
  - S0 ^= (S0>>>19) ^ (S0>>>28)
  - S1 ^= (S1>>>61) ^ (S1>>>39)
  - S2 ^= (S2>>>1) ^ (S2>>>6)
  - S3 ^= (S3>>>10) ^ (S3>>>17)
  - S4 ^= (S4>>>7) ^ (S4>>>41)
- xor_down, selected by etat_down_i:
  - 00: pass-through.
  - 01: S3 ^= K[127:64], S4 ^= K[63:0].
  - 10: S4 ^= 64'h1 (domain separation).
  - 11: both 01 and 10.
- State register: on a rising edge with enable_i=1, state_reg <= xor_down output; otherwise it holds. permutation_o = state_reg.
- Cipher register: on a rising edge with enable_cipher=1, sortie_cipher <= S0 of the xor_up output (the ciphertext of the current block). Otherwise it holds.
- Tag register: on a rising edge with enable_tag=1, sortie_tag <= {S3,S4} of the xor_down output. Otherwise it holds.
- Reset (resetb_i=0, asynchronous): state_reg, sortie_cipher and sortie_tag are all cleared to 0, including mid-operation. Normal operation resumes on the first edge after release.
- Latency: one round per enabled cycle; 12 cycles for p12, 6 cycles for p6.
- The block contains no FSM; sequencing belongs to the external controller.
- Simultaneous enables are independent: all three registers may load on the same edge.

Optional Feature:
- ASCON_PERM_ASSERT_EN
- Defined: concurrent assertions are compiled in. They flag round_i > 11 whenever enable_i=1, and any X/Z on the control inputs while resetb_i=1.
- Undefined: no assertion code; the functional RTL is identical.

Decomposition:
- Package ascon_pack holds:
  - typedef type_state (logic [63:0] array [0:4]);
  - the S-box function or lookup table;
  - the rotation amounts.
- Sub-module ascon_round: purely combinational. Inputs are the state and round_i; output is the state after constant addition, S-box and linear layer. Instantiated once.

Test Plan:
- Reset: hold resetb_i=0 for 25 ns -> permutation_o, sortie_cipher and sortie_tag are all 0 while reset is held.
- First plaintext block:
  - Stimulus: select_i=1, permutation_i = {4608da0e76fcee25, 876f2d998dd3ed21, 5d5b8b59b7ac16ee, e23c656f97f63dc8, 3e09499302483746}, xor_data_i = 436F6E636576657A, etat_up_i=01, enable_cipher=1, round_i=6.
  - Response: sortie_cipher = 0567B46D138A8B5F after the edge.
- Round constant isolation: compare against the golden model with etat_*=00, select_i=1, for round_i in {0, 6, 11}. Round 6 must differ from round 7 only through the c=0x96 vs c=0x87 injection.
- Enable hold: enable_i=0 for 3 cycles -> permutation_o is unchanged; same check for the cipher and tag registers with their enables low.
- Full p6 sequence:
  - Stimulus: 6 cycles with round_i 6..11 and select_i=0 after the first cycle, repeated for the plaintext blocks 204153434F4E2065, 6E2053797374656D and 566572696C6F6780.
  - Response: each sortie_cipher matches the reference ASCON-128 model.
- Finalisation:
  - Stimulus: etat_up_i=10 at round 0, rounds 0..11, etat_down_i=01 and enable_tag=1 at round 11.
  - Response: sortie_tag equals the ASCON-128 reference tag.

Source files
------------

// File: rtl/ascon_pack.sv
// ascon_pack: shared types and helpers for the ASCON-128 permutation datapath.
//   type_state   : five 64-bit words S0..S4
//   RotA / RotB  : linear-layer rotate-right amounts per word
//   sbox5        : 5-bit S-box, bit 4 of the argument is the S0 bit of a column
//   rotr         : 64-bit rotate right
//   round_const  : round constant byte, zero for round indices above 11
package ascon_pack;

    typedef logic [63:0] type_state [0:4];

    localparam int unsigned RotA [0:4] = '{19, 61, 1, 10, 7};
    localparam int unsigned RotB [0:4] = '{28, 39, 6, 17, 41};

    // Boolean form of the S-box; equivalent to the 32-entry table.
    function automatic logic [4:0] sbox5(input logic [4:0] x);
        logic x0, x1, x2, x3, x4;
        logic t0, t1, t2, t3, t4;
        x0 = x[4];
        x1 = x[3];
        x2 = x[2];
        x3 = x[1];
        x4 = x[0];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        return {x0, x1, x2, x3, x4};
    endfunction

    function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [7:0] round_const(input logic [3:0] r);
        if (r > 4'd11) begin
            return 8'h00;
        end
        return {4'hF - r, r};
    endfunction

endpackage

// File: rtl/ascon_round.sv
// ascon_round: one combinational ASCON permutation round.
//   state_i : state entering the round
//   round_i : round index 0..11 (constant is zero above 11)
//   state_o : state after constant addition, S-box layer and linear layer
module ascon_round
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);

    type_state  add_s;
    type_state  sub_s;
    logic [4:0] col_v;

    always_comb begin
        add_s    = state_i;
        add_s[2] = state_i[2] ^ {56'h0, round_const(round_i)};
    end

    // Bit-sliced S-box: column c gathers bit c of every word.
    always_comb begin
        sub_s = add_s;
        col_v = '0;
        for (int c = 0; c < 64; c++) begin
            col_v = sbox5({add_s[0][c], add_s[1][c], add_s[2][c], add_s[3][c], add_s[4][c]});
            sub_s[0][c] = col_v[4];
            sub_s[1][c] = col_v[3];
            sub_s[2][c] = col_v[2];
            sub_s[3][c] = col_v[1];
            sub_s[4][c] = col_v[0];
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            state_o[i] = sub_s[i] ^ rotr(sub_s[i], RotA[i]) ^ rotr(sub_s[i], RotB[i]);
        end
    end

endmodule

// File: rtl/ascon_permutation_final.sv
// ascon_permutation_final: registered ASCON-128 datapath, one round per enabled clock.
// Path: mux -> xor_up -> ascon_round -> xor_down -> state register.
//   clock_i / resetb_i        : clock, asynchronous active-low reset
//   select_i, permutation_i   : round input source (1: external state, 0: state register)
//   round_i                   : round index selecting the round constant
//   enable_i                  : state register load enable
//   xor_key_i, xor_data_i     : key K and data block for the XOR injections
//   etat_up_i / etat_down_i   : pre-round / post-round XOR mode
//   enable_cipher/enable_tag  : output register load enables
//   permutation_o             : current state register
//   sortie_cipher, sortie_tag : registered ciphertext block and tag
// Optional: define ASCON_PERM_ASSERT_EN to compile in control-input assertions.
module ascon_permutation_final
    import ascon_pack::*;
(
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         select_i,
    input  type_state    permutation_i,
    input  logic [3:0]   round_i,
    input  logic         enable_i,
    input  logic [127:0] xor_key_i,
    input  logic [63:0]  xor_data_i,
    input  logic [1:0]   etat_up_i,
    input  logic [1:0]   etat_down_i,
    input  logic         enable_cipher,
    input  logic         enable_tag,
    output type_state    permutation_o,
    output logic [63:0]  sortie_cipher,
    output logic [127:0] sortie_tag
);

    type_state    state_q, state_d;
    type_state    mux_s, up_s, round_s, down_s;
    logic [63:0]  cipher_q, cipher_d;
    logic [127:0] tag_q, tag_d;

    always_comb begin
        if (select_i) begin
            mux_s = permutation_i;
        end else begin
            mux_s = state_q;
        end
    end

    always_comb begin
        up_s = mux_s;
        if (etat_up_i[0]) begin
            up_s[0] = mux_s[0] ^ xor_data_i;
        end
        if (etat_up_i[1]) begin
            up_s[1] = mux_s[1] ^ xor_key_i[127:64];
            up_s[2] = mux_s[2] ^ xor_key_i[63:0];
        end
    end

    ascon_round u_round (
        .state_i (up_s),
        .round_i (round_i),
        .state_o (round_s)
    );

    // Key and domain-separation bit may both land on S4 in mode 11.
    always_comb begin
        down_s = round_s;
        if (etat_down_i[0]) begin
            down_s[3] = round_s[3] ^ xor_key_i[127:64];
            down_s[4] = round_s[4] ^ xor_key_i[63:0];
        end
        if (etat_down_i[1]) begin
            down_s[4] = down_s[4] ^ 64'h1;
        end
    end

    always_comb begin
        state_d  = state_q;
        cipher_d = cipher_q;
        tag_d    = tag_q;
        if (enable_i) begin
            state_d = down_s;
        end
        if (enable_cipher) begin
            cipher_d = up_s[0];
        end
        if (enable_tag) begin
            tag_d = {down_s[3], down_s[4]};
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q  <= '{default: '0};
            cipher_q <= '0;
            tag_q    <= '0;
        end else begin
            state_q  <= state_d;
            cipher_q <= cipher_d;
            tag_q    <= tag_d;
        end
    end

    assign permutation_o = state_q;
    assign sortie_cipher = cipher_q;
    assign sortie_tag    = tag_q;

`ifdef ASCON_PERM_ASSERT_EN
    round_range_a: assert property (@(posedge clock_i) disable iff (!resetb_i)
        enable_i |-> (round_i <= 4'd11));
    ctrl_known_a: assert property (@(posedge clock_i) disable iff (!resetb_i)
        !$isunknown({select_i, round_i, enable_i, etat_up_i, etat_down_i,
                     enable_cipher, enable_tag}));
`else
    // Assertions not compiled in this build.
`endif

endmodule

// File: tb/tb_ascon_permutation_final.sv
// Scoreboard bench: the driver computes expected register contents from a
// table-driven ASCON model and queues them; the monitor checks them on the falling edge.
module tb_ascon_permutation_final;
    import ascon_pack::*;

    logic         clock_i;
    logic         resetb_i;
    logic         sel_s;
    logic [319:0] pin_flat;
    type_state    perm_in;
    logic [3:0]   round_s;
    logic         en_s;
    logic [127:0] key_s;
    logic [63:0]  data_s;
    logic [1:0]   up_s;
    logic [1:0]   down_s;
    logic         ec_s;
    logic         et_s;
    type_state    perm_out;
    logic [63:0]  cipher_o;
    logic [127:0] tag_o;
    logic [319:0] out_flat;

    assign perm_in[0] = pin_flat[319:256];
    assign perm_in[1] = pin_flat[255:192];
    assign perm_in[2] = pin_flat[191:128];
    assign perm_in[3] = pin_flat[127:64];
    assign perm_in[4] = pin_flat[63:0];
    assign out_flat   = {perm_out[0], perm_out[1], perm_out[2], perm_out[3], perm_out[4]};

    ascon_permutation_final dut (
        .clock_i       (clock_i),
        .resetb_i      (resetb_i),
        .select_i      (sel_s),
        .permutation_i (perm_in),
        .round_i       (round_s),
        .enable_i      (en_s),
        .xor_key_i     (key_s),
        .xor_data_i    (data_s),
        .etat_up_i     (up_s),
        .etat_down_i   (down_s),
        .enable_cipher (ec_s),
        .enable_tag    (et_s),
        .permutation_o (perm_out),
        .sortie_cipher (cipher_o),
        .sortie_tag    (tag_o)
    );

    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    int unsigned cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        logic [127:0] w;
        w = {v, v} >> n;
        return w[63:0];
    endfunction

    function automatic logic [319:0] ref_round(input logic [319:0] st, input int r);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  idx;
        logic [4:0]  o;
        for (int i = 0; i < 5; i++) x[i] = st[319-64*i -: 64];
        if (r <= 11) x[2] = x[2] ^ 64'((15 - r) * 16 + r);
        for (int c = 0; c < 64; c++) begin
            idx = {x[0][c], x[1][c], x[2][c], x[3][c], x[4][c]};
            o = SBOX[idx];
            for (int i = 0; i < 5; i++) y[i][c] = o[4-i];
        end
        y[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
        y[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
        y[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
        y[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
        y[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
        return {y[0], y[1], y[2], y[3], y[4]};
    endfunction

    typedef struct {
        int unsigned  due;
        logic [319:0] st;
        logic [63:0]  ci;
        logic [127:0] tg;
        string        nm;
    } exp_t;

    exp_t         sb_q [$];
    logic [319:0] m_state = '0;
    logic [63:0]  m_cipher = '0;
    logic [127:0] m_tag = '0;
    int           n_vec = 0;
    int           n_bad = 0;
    bit           done = 0;
    exp_t         mon_e;

    function automatic void check(input string nm, input string f,
                                  input logic [319:0] act, input logic [319:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s.%s got %0h want %0h", nm, f, act, want);
        end
    endfunction

    always @(negedge clock_i) begin
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            check(mon_e.nm, "state", out_flat, mon_e.st);
            check(mon_e.nm, "cipher", {256'h0, cipher_o}, {256'h0, mon_e.ci});
            check(mon_e.nm, "tag", {192'h0, tag_o}, {192'h0, mon_e.tg});
        end
        if (done && sb_q.size() > 0) begin
            n_bad += sb_q.size();
            $display("FAIL drain %0d expectations never checked", sb_q.size());
            sb_q.delete();
        end
    end

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic void push_exp(input int unsigned due, input string nm);
        exp_t e;
        e.due = due;
        e.st  = m_state;
        e.ci  = m_cipher;
        e.tg  = m_tag;
        e.nm  = nm;
        sb_q.push_back(e);
    endfunction

    // Apply the current inputs for one clock and queue the expected register values.
    task automatic apply(input string nm, input bit use_lit = 1'b0,
                         input logic [63:0] lit = 64'h0);
        logic [319:0] a;
        logic [319:0] d;
        exp_t         e;
        a = sel_s ? pin_flat : m_state;
        if (up_s[0]) a[319:256] = a[319:256] ^ data_s;
        if (up_s[1]) begin
            a[255:192] = a[255:192] ^ key_s[127:64];
            a[191:128] = a[191:128] ^ key_s[63:0];
        end
        d = ref_round(a, int'(round_s));
        if (down_s[0]) begin
            d[127:64] = d[127:64] ^ key_s[127:64];
            d[63:0]   = d[63:0] ^ key_s[63:0];
        end
        if (down_s[1]) d[63:0] = d[63:0] ^ 64'h1;
        if (ec_s) m_cipher = a[319:256];
        if (et_s) m_tag = d[127:0];
        if (en_s) m_state = d;
        e.due = cyc + 1;
        e.st  = m_state;
        e.ci  = use_lit ? lit : m_cipher;
        e.tg  = m_tag;
        e.nm  = nm;
        sb_q.push_back(e);
        @(posedge clock_i);
        @(negedge clock_i);
    endtask

    task automatic ctrl(input bit sel, input int rnd, input bit en, input logic [1:0] up,
                        input logic [1:0] dn, input bit ec, input bit et);
        sel_s   = sel;
        round_s = 4'(rnd);
        en_s    = en;
        up_s    = up;
        down_s  = dn;
        ec_s    = ec;
        et_s    = et;
    endtask

    logic [63:0] blk [3];
    logic [63:0] nonce_hi, nonce_lo;

    initial begin
        resetb_i = 1'b0;
        pin_flat = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
        key_s    = {rnd64(), rnd64()};
        data_s   = rnd64();
        ctrl(1, 3, 1, 2'b11, 2'b11, 1, 1);
        // Reset held across three rising edges with every enable high.
        for (int k = 0; k < 3; k++) begin
            push_exp(cyc + 1, "reset_hold");
            @(posedge clock_i);
            @(negedge clock_i);
        end
        resetb_i = 1'b1;

        // First plaintext block: ciphertext is S0 xor data.
        pin_flat = {64'h4608da0e76fcee25, 64'h876f2d998dd3ed21, 64'h5d5b8b59b7ac16ee,
                    64'he23c656f97f63dc8, 64'h3e09499302483746};
        data_s   = 64'h436F6E636576657A;
        ctrl(1, 6, 1, 2'b01, 2'b00, 1, 0);
        apply("first_block", 1'b1, 64'h0567B46D138A8B5F);

        // Round constant isolation, including the zero-constant indices via the tag path.
        ctrl(1, 0, 1, 2'b00, 2'b00, 0, 0);
        pin_flat = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
        apply("rc_round0");
        round_s = 4'd6;
        apply("rc_round6");
        round_s = 4'd7;
        apply("rc_round7");
        round_s = 4'd11;
        apply("rc_round11");
        ctrl(1, 13, 0, 2'b00, 2'b00, 0, 1);
        apply("rc_round13");
        round_s = 4'd15;
        apply("rc_round15");

        // Enable hold: nothing loads while inputs churn.
        for (int k = 0; k < 3; k++) begin
            pin_flat = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
            data_s   = rnd64();
            ctrl($urandom_range(0, 1), $urandom_range(0, 11), 0, 2'($urandom), 2'($urandom),
                 0, 0);
            apply("enable_hold");
        end

        // ASCON-128 flow: init p12, three p6 plaintext blocks, finalisation p12.
        key_s    = {rnd64(), rnd64()};
        nonce_hi = rnd64();
        nonce_lo = rnd64();
        pin_flat = {64'h80400c0600000000, key_s, nonce_hi, nonce_lo};
        for (int r = 0; r < 12; r++) begin
            ctrl(r == 0, r, 1, 2'b00, (r == 11) ? 2'b11 : 2'b00, 0, 0);
            apply("init");
        end
        blk[0] = 64'h204153434F4E2065;
        blk[1] = 64'h6E2053797374656D;
        blk[2] = 64'h566572696C6F6780;
        for (int b = 0; b < 3; b++) begin
            data_s = blk[b];
            for (int r = 6; r < 12; r++) begin
                ctrl(0, r, 1, (r == 6) ? 2'b01 : 2'b00, 2'b00, r == 6, 0);
                apply("p6_block");
            end
        end
        for (int r = 0; r < 12; r++) begin
            ctrl(0, r, 1, (r == 0) ? 2'b10 : 2'b00, (r == 11) ? 2'b01 : 2'b00, 0, r == 11);
            apply("final");
        end

        // Randomized traffic with an asynchronous reset pulse between edges.
        for (int i = 0; i < 150; i++) begin
            pin_flat = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
            data_s   = rnd64();
            key_s    = {rnd64(), rnd64()};
            en_s     = 1'($urandom);
            ctrl($urandom_range(0, 1), en_s ? $urandom_range(0, 11) : $urandom_range(0, 15),
                 en_s, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
            if (i == 75) begin
                #1 resetb_i = 1'b0;
                #1 resetb_i = 1'b1;
                m_state  = '0;
                m_cipher = '0;
                m_tag    = '0;
                ctrl(0, 0, 0, 2'b00, 2'b00, 0, 0);
                apply("async_reset_pulse");
            end else begin
                apply("random");
            end
        end

        // Reset held mid-operation.
        ctrl(0, 5, 1, 2'b11, 2'b11, 1, 1);
        #2 resetb_i = 1'b0;
        m_state  = '0;
        m_cipher = '0;
        m_tag    = '0;
        for (int k = 0; k < 2; k++) begin
            push_exp(cyc + 1, "reset_mid");
            @(posedge clock_i);
            @(negedge clock_i);
        end
        resetb_i = 1'b1;
        ctrl(0, 5, 1, 2'b01, 2'b10, 1, 1);
        apply("after_reset");

        @(negedge clock_i);
        @(negedge clock_i);
        done = 1'b1;
        @(negedge clock_i);
        @(posedge clock_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
